// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA/text-overlay constants and types
package vga_pkg;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int FONT_ADDR_W = 11;

  localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
  localparam logic [11:0] COLOR_ORANGE = 12'hF80;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DOWN = 2'd2
  } sel_req_t;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/menu_sel_ctrl.sv
// rtl/menu_sel_ctrl.sv - menu cursor: button edges, vblank-applied moves, confirm pulse
module menu_sel_ctrl
  import vga_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       vblnk_in,
  output logic [3:0] sel_idx,
  output logic       sel_ok
);

  localparam logic [3:0] LAST = 4'(ROWS - 1);

  logic     up_q, down_q, ok_q, vblnk_q;
  logic     up_rise, down_rise, ok_rise, vblnk_rise;
  sel_req_t pend;
  logic [3:0] sel_next;

  assign up_rise    = btn_up & ~up_q;
  assign down_rise  = btn_down & ~down_q;
  assign ok_rise    = btn_ok & ~ok_q;
  assign vblnk_rise = vblnk_in & ~vblnk_q;

  always_comb begin
    sel_next = sel_idx;
    if (vblnk_rise) begin
      case (pend)
        REQ_UP:   sel_next = (sel_idx == 4'd0) ? LAST : sel_idx - 4'd1;
        REQ_DOWN: sel_next = (sel_idx == LAST) ? 4'd0 : sel_idx + 4'd1;
        default:  sel_next = sel_idx;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      ok_q    <= 1'b0;
      vblnk_q <= 1'b0;
      pend    <= REQ_NONE;
      sel_idx <= 4'd0;
      sel_ok  <= 1'b0;
    end else begin
      up_q    <= btn_up;
      down_q  <= btn_down;
      ok_q    <= btn_ok;
      vblnk_q <= vblnk_in;
      sel_idx <= sel_next;
      sel_ok  <= ok_rise;
      // A fresh single-direction press always wins; simultaneous up+down is ignored.
      if (up_rise ^ down_rise)
        pend <= up_rise ? REQ_UP : REQ_DOWN;
      else if (vblnk_rise)
        pend <= REQ_NONE;
    end
  end

endmodule

// File: rtl/menu_text_render.sv
// rtl/menu_text_render.sv - 4-stage text overlay with menu cursor; MENU_BLINK_EN blinks the highlight
module menu_text_render
  import vga_pkg::*;
#(
  parameter logic [10:0] XPOS      = 11'd300,
  parameter logic [10:0] YPOS      = 11'd200,
  parameter int          COLS      = 16,
  parameter int          ROWS      = 4,
  parameter logic [11:0] TXT_COLOR = COLOR_WHITE,
  parameter logic [11:0] HL_COLOR  = COLOR_ORANGE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            vcount_in,
  input  logic [10:0]            hcount_in,
  input  logic                   vsync_in,
  input  logic                   hsync_in,
  input  logic                   vblnk_in,
  input  logic                   hblnk_in,
  input  logic [11:0]            rgb_in,
  output logic [10:0]            vcount_out,
  output logic [10:0]            hcount_out,
  output logic                   vsync_out,
  output logic                   hsync_out,
  output logic                   vblnk_out,
  output logic                   hblnk_out,
  output logic [11:0]            rgb_out,
  output logic [7:0]             char_xy,
  input  logic [6:0]             char_code,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             char_pixels,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_ok,
  output logic [3:0]             sel_idx,
  output logic                   sel_ok
);

  localparam logic [10:0] BOX_W = 11'(CHAR_W * COLS);
  localparam logic [10:0] BOX_H = 11'(CHAR_H * ROWS);

  logic [10:0] rx, ry;
  logic        in_box;
  vga_bus_t    bus_in;
  vga_bus_t    bus_d [3];

  logic [3:0] s1_line, s2_line;
  logic [2:0] s1_bit, s2_bit, s3_bit;
  logic [3:0] s1_row, s2_row, s3_row;
  logic       s1_in_box, s2_in_box, s3_in_box;
  logic       hl_on, pixel_on;
  logic [11:0] glyph_color;

  assign rx     = hcount_in - XPOS;
  assign ry     = vcount_in - YPOS;
  assign in_box = (hcount_in >= XPOS) && (rx < BOX_W) && (vcount_in >= YPOS) && (ry < BOX_H);
  assign bus_in = {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in, rgb_in};

  // Text ROM answers one clock after char_xy, so the line index is delayed to meet it.
  assign font_addr = {char_code, s2_line};

  menu_sel_ctrl #(.ROWS(ROWS)) u_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_ok   (btn_ok),
    .vblnk_in (vblnk_in),
    .sel_idx  (sel_idx),
    .sel_ok   (sel_ok)
  );

`ifdef MENU_BLINK_EN
  logic [5:0] frame_cnt;
  logic       blink_vblnk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt     <= 6'd0;
      blink_vblnk_q <= 1'b0;
    end else begin
      blink_vblnk_q <= vblnk_in;
      if (vblnk_in && !blink_vblnk_q)
        frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign hl_on = ~frame_cnt[5];
`else
  assign hl_on = 1'b1;
`endif

  assign pixel_on    = s3_in_box && char_pixels[3'd7 - s3_bit];
  assign glyph_color = (hl_on && (s3_row == sel_idx)) ? HL_COLOR : TXT_COLOR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy    <= 8'h00;
      s1_line    <= 4'd0;
      s1_bit     <= 3'd0;
      s1_row     <= 4'd0;
      s1_in_box  <= 1'b0;
      s2_line    <= 4'd0;
      s2_bit     <= 3'd0;
      s2_row     <= 4'd0;
      s2_in_box  <= 1'b0;
      s3_bit     <= 3'd0;
      s3_row     <= 4'd0;
      s3_in_box  <= 1'b0;
      bus_d      <= '{default: '0};
      vcount_out <= 11'd0;
      hcount_out <= 11'd0;
      vsync_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      char_xy   <= in_box ? {ry[7:4], rx[6:3]} : 8'h00;
      s1_line   <= ry[3:0];
      s1_bit    <= rx[2:0];
      s1_row    <= ry[7:4];
      s1_in_box <= in_box;

      s2_line   <= s1_line;
      s2_bit    <= s1_bit;
      s2_row    <= s1_row;
      s2_in_box <= s1_in_box;

      s3_bit    <= s2_bit;
      s3_row    <= s2_row;
      s3_in_box <= s2_in_box;

      bus_d[0] <= bus_in;
      bus_d[1] <= bus_d[0];
      bus_d[2] <= bus_d[1];

      vcount_out <= bus_d[2].vcount;
      hcount_out <= bus_d[2].hcount;
      vsync_out  <= bus_d[2].vsync;
      hsync_out  <= bus_d[2].hsync;
      vblnk_out  <= bus_d[2].vblnk;
      hblnk_out  <= bus_d[2].hblnk;
      rgb_out    <= pixel_on ? glyph_color : bus_d[2].rgb;
    end
  end

endmodule

// File: tb/tb_menu_text_render.sv
// tb/tb_menu_text_render.sv - randomized self-checking bench for menu_text_render
module tb_menu_text_render;

  localparam int XPOS = 300;
  localparam int YPOS = 200;
  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam logic [11:0] TXT = 12'hFFF;
  localparam logic [11:0] HL  = 12'hF80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 0, hsync_in = 0, vblnk_in = 0, hblnk_in = 0;
  logic [11:0] rgb_in = '0;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  char_pixels;
  logic        btn_up = 0, btn_down = 0, btn_ok = 0;
  logic [3:0]  sel_idx;
  logic        sel_ok;

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 0;
  bit  rnd = 0;
  bit  font_mode = 0;

  always #5 clk = ~clk;

  menu_text_render dut (
    .clk(clk), .rst_n(rst_n),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out),
    .char_xy(char_xy), .char_code(char_code),
    .font_addr(font_addr), .char_pixels(char_pixels),
    .btn_up(btn_up), .btn_down(btn_down), .btn_ok(btn_ok),
    .sel_idx(sel_idx), .sel_ok(sel_ok)
  );

  function automatic logic [7:0] font_fn(input bit mode, input int c, input int l);
    if (!mode) return 8'h80;
    return 8'((c * 37 + l * 11 + 5) % 256);
  endfunction

  // Text ROM echoes its address; font ROM returns a known pattern.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code   <= '0;
      char_pixels <= '0;
    end else begin
      char_code   <= char_xy[6:0];
      char_pixels <= font_fn(font_mode, int'(font_addr[10:4]), int'(font_addr[3:0]));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model.
  typedef struct {
    int h; int v;
    bit vs; bit hs; bit vb; bit hb;
    logic [11:0] rgb;
    bit fm;
  } pix_t;

  pix_t q[$];
  logic [11:0] exp_rgb;
  int  exp_h, exp_v, exp_xy, exp_sel;
  bit  exp_vs, exp_hs, exp_vb, exp_hb, exp_ok;
  int  m_sel, m_pend;
  bit  p_up, p_dn, p_ok, p_vb;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_sel = 0; m_pend = 0;
      p_up = 0; p_dn = 0; p_ok = 0; p_vb = 0;
      exp_rgb = 0; exp_h = 0; exp_v = 0; exp_xy = 0; exp_sel = 0;
      exp_vs = 0; exp_hs = 0; exp_vb = 0; exp_hb = 0; exp_ok = 0;
    end else begin
      pix_t cur, e;
      int dx, dy;
      bit up_r, dn_r;
      cur = '{int'(hcount_in), int'(vcount_in), vsync_in, hsync_in, vblnk_in, hblnk_in, rgb_in, font_mode};
      dx = cur.h - XPOS; dy = cur.v - YPOS;
      if (dx >= 0 && dx < 8 * COLS && dy >= 0 && dy < 16 * ROWS)
        exp_xy = (dy / 16) * 16 + dx / 8;
      else
        exp_xy = 0;
      q.push_back(cur);
      if (q.size() == 4) begin
        logic [7:0] pix;
        e = q.pop_front();
        dx = e.h - XPOS; dy = e.v - YPOS;
        exp_rgb = e.rgb;
        if (dx >= 0 && dx < 8 * COLS && dy >= 0 && dy < 16 * ROWS) begin
          pix = font_fn(e.fm, ((dy / 16) % 8) * 16 + dx / 8, dy % 16);
          if (pix[7 - dx % 8]) exp_rgb = (dy / 16 == m_sel) ? HL : TXT;
        end
        exp_h = e.h; exp_v = e.v;
        exp_vs = e.vs; exp_hs = e.hs; exp_vb = e.vb; exp_hb = e.hb;
      end
      exp_ok = btn_ok && !p_ok;
      up_r = btn_up && !p_up;
      dn_r = btn_down && !p_dn;
      if (vblnk_in && !p_vb) begin
        if (m_pend == 1) m_sel = (m_sel + ROWS - 1) % ROWS;
        if (m_pend == 2) m_sel = (m_sel + 1) % ROWS;
        m_pend = 0;
      end
      if (up_r && !dn_r) m_pend = 1;
      else if (dn_r && !up_r) m_pend = 2;
      exp_sel = m_sel;
      p_up = btn_up; p_dn = btn_down; p_ok = btn_ok; p_vb = vblnk_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
      chk("hcount_out", 32'(hcount_out), 32'(exp_h));
      chk("vcount_out", 32'(vcount_out), 32'(exp_v));
      chk("syncs_out", {28'd0, vsync_out, hsync_out, vblnk_out, hblnk_out},
          {28'd0, exp_vs, exp_hs, exp_vb, exp_hb});
      chk("char_xy", 32'(char_xy), 32'(exp_xy));
      chk("sel_idx", 32'(sel_idx), 32'(exp_sel));
      chk("sel_ok", 32'(sel_ok), 32'(exp_ok));
    end
  end

  task automatic drive(input int h, input int v);
    @(posedge clk); #2;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    if (rnd) begin
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      hblnk_in = 1'($urandom);
      rgb_in   = 12'($urandom);
      if ($urandom_range(0, 59) == 0) btn_up   = ~btn_up;
      if ($urandom_range(0, 59) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 59) == 0) btn_ok   = ~btn_ok;
      if ($urandom_range(0, 199) == 0) vblnk_in = ~vblnk_in;
    end else begin
      rgb_in = 12'h123;
    end
  endtask

  task automatic vblank_pulse();
    vblnk_in = 1'b1;
    repeat (3) drive(0, 0);
    vblnk_in = 1'b0;
    repeat (2) drive(0, 0);
  endtask

  task automatic scan_count(input int v, input logic [11:0] col, output int n);
    n = 0;
    for (int h = XPOS - 4; h < XPOS + 8 * COLS + 4; h++) begin
      drive(h, v);
      if (rgb_out == col) n++;
    end
    repeat (5) begin
      drive(0, 0);
      if (rgb_out == col) n++;
    end
  endtask

  task automatic rand_frame(input int nlines);
    for (int li = 0; li < nlines; li++) begin
      int v;
      v = YPOS - 2 + $urandom_range(0, 16 * ROWS + 3);
      for (int h = XPOS - 6; h < XPOS + 8 * COLS + 6; h++) drive(h, v);
    end
    repeat (2) drive(0, 0);
    font_mode = 1'($urandom);
    vblnk_in = 1'b1;
    repeat (4) drive(0, 0);
    vblnk_in = 1'b0;
    repeat (2) drive(0, 0);
  endtask

  initial begin
    int n;
    int seq [5] = '{1, 2, 3, 0, 1};

    repeat (3) @(posedge clk);
    #2;
    chk("reset_rgb_out", 32'(rgb_out), 32'h0);
    chk("reset_char_xy", 32'(char_xy), 32'h0);
    chk("reset_sel_idx", 32'(sel_idx), 32'h0);
    chk("reset_sel_ok", 32'(sel_ok), 32'h0);
    chk("reset_hcount_out", 32'(hcount_out), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    drive(XPOS + 9, YPOS + 17);
    drive(0, 0);
    chk("lat_char_xy", 32'(char_xy), 32'h11);
    drive(0, 0);
    chk("lat_font_addr", 32'(font_addr), {21'd0, 7'h11, 4'd1});
    repeat (4) drive(0, 0);

    for (int i = 0; i < 5; i++) begin
      btn_down = 1'b1;
      repeat (3) drive(0, 0);
      btn_down = 1'b0;
      repeat (2) drive(0, 0);
      vblank_pulse();
      chk("down_seq_sel_idx", 32'(sel_idx), 32'(seq[i]));
    end

    scan_count(YPOS, TXT, n);
    chk("row0_txt_pixels", 32'(n), 32'd16);
    scan_count(YPOS + 16, HL, n);
    chk("row1_hl_pixels", 32'(n), 32'd16);

    btn_up = 1'b1; btn_down = 1'b1;
    repeat (3) drive(0, 0);
    btn_up = 1'b0; btn_down = 1'b0;
    drive(0, 0);
    vblank_pulse();
    chk("updown_same_sel_idx", 32'(sel_idx), 32'd1);

    n = 0;
    btn_ok = 1'b1;
    repeat (10) begin
      drive(0, 0);
      if (sel_ok) n++;
    end
    btn_ok = 1'b0;
    repeat (3) begin
      drive(0, 0);
      if (sel_ok) n++;
    end
    chk("ok_pulse_count", 32'(n), 32'd1);

    rnd = 1'b1;
    for (int f = 0; f < 6; f++) rand_frame(10);

    for (int h = XPOS; h < XPOS + 40; h++) drive(h, YPOS + 3);
    #3;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_rgb_out", 32'(rgb_out), 32'h0);
    chk("midreset_hcount_out", 32'(hcount_out), 32'h0);
    chk("midreset_char_xy", 32'(char_xy), 32'h0);
    chk("midreset_sel_idx", 32'(sel_idx), 32'h0);
    chk("midreset_sel_ok", 32'(sel_ok), 32'h0);
    repeat (2) drive(XPOS + 5, YPOS + 3);
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int f = 0; f < 4; f++) rand_frame(10);
    rnd = 1'b0;
    repeat (6) drive(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
